// File: rtl/pid_mc.sv
// pid_mc -- multi-channel PID controller with a single time-shared multiplier.
//
// Each sample takes six clocks. On acceptance the channel and the saturated
// error are latched. The P, I, D1 and D2 products are then formed one per
// cycle on one shared multiplier, and the result is resolved and written
// back in FIN. Per-channel gains and state live in small register arrays
// that are loaded over a simple address/data config port.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   reg_we       config write strobe
//   reg_ready    config write accepted this cycle (controller idle)
//   reg_addr     {channel, index}: 0 kp, 1 ki, 2 kd1, 3 kd2, 4 clear state
//   reg_data     signed config data
//   in_valid     sample valid
//   in_ready     sample accepted when high together with in_valid
//   in_ch        sample channel
//   target       signed setpoint
//   measurement  signed measurement
//   out_valid    one-cycle result strobe
//   out_ch       result channel
//   out_data     signed, limited controller output
//
// state  | meaning
// IDLE   | waiting; config writes and sample acceptance happen here
// MUL_P  | kp * err
// MUL_I  | ki * (err + prev_err)
// MUL_D1 | kd1 * (err - prev_err)
// MUL_D2 | kd2 * prev_d, derivative term resolved
// FIN    | anti-windup, output limit, channel write-back
module pid_mc #(
  parameter int D_WIDTH = 18,
  parameter int Q_BITS  = 15,
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int LIM_MAX = 4096,
  parameter int LIM_MIN = -4096,
  parameter int AW_MODE = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      reg_we,
  output logic                      reg_ready,
  input  logic [CH_W+2:0]           reg_addr,
  input  logic signed [D_WIDTH-1:0] reg_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CH_W-1:0]           in_ch,
  input  logic signed [D_WIDTH-1:0] target,
  input  logic signed [D_WIDTH-1:0] measurement,
  output logic                      out_valid,
  output logic [CH_W-1:0]           out_ch,
  output logic signed [D_WIDTH-1:0] out_data
);

  localparam int PW   = 2 * D_WIDTH + 1;  // product width
  localparam int SW   = PW + 1;           // headroom for saturation inputs
  localparam int SUMW = D_WIDTH + 2;      // width of the output-stage sums

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] MUL_P  = 3'd1;
  localparam logic [2:0] MUL_I  = 3'd2;
  localparam logic [2:0] MUL_D1 = 3'd3;
  localparam logic [2:0] MUL_D2 = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  localparam logic signed [SW-1:0] SAT_HI = {{(SW-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO = {{(SW-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};
  localparam logic signed [SUMW-1:0] LIM_HI = SUMW'(LIM_MAX);
  localparam logic signed [SUMW-1:0] LIM_LO = SUMW'(LIM_MIN);

  function automatic logic signed [D_WIDTH-1:0] sat_d(input logic signed [SW-1:0] x);
    if (x > SAT_HI)      return SAT_HI[D_WIDTH-1:0];
    else if (x < SAT_LO) return SAT_LO[D_WIDTH-1:0];
    else                 return x[D_WIDTH-1:0];
  endfunction

  logic signed [D_WIDTH-1:0] kp_q    [N_CH];
  logic signed [D_WIDTH-1:0] ki_q    [N_CH];
  logic signed [D_WIDTH-1:0] kd1_q   [N_CH];
  logic signed [D_WIDTH-1:0] kd2_q   [N_CH];
  logic signed [D_WIDTH-1:0] i_acc_q [N_CH];
  logic signed [D_WIDTH-1:0] perr_q  [N_CH];
  logic signed [D_WIDTH-1:0] pd_q    [N_CH];

  logic [2:0]                state_q;
  logic [CH_W-1:0]           ch_q;
  logic signed [D_WIDTH-1:0] err_q, p_q, it_q, d_q;
  logic signed [PW-1:0]      d1_q;
  logic                      out_valid_q;
  logic [CH_W-1:0]           out_ch_q;
  logic signed [D_WIDTH-1:0] out_data_q;

  logic                      idle, accept, wr_en, ch_ok;
  logic [CH_W-1:0]           wr_ch;
  logic [2:0]                wr_idx;
  logic signed [D_WIDTH:0]   diff;
  logic signed [D_WIDTH-1:0] err_d;

  assign idle      = (state_q == IDLE);
  assign reg_ready = idle;
  assign in_ready  = idle && !reg_we;
  assign accept    = in_ready && in_valid;
  assign wr_ch     = reg_addr[CH_W+2:3];
  assign wr_idx    = reg_addr[2:0];
  assign wr_en     = reg_we && idle && (int'(wr_ch) < N_CH);
  assign ch_ok     = (int'(ch_q) < N_CH);

  assign diff  = (D_WIDTH+1)'(target) - (D_WIDTH+1)'(measurement);
  assign err_d = sat_d(SW'(diff));

  // Current channel's operands
  logic signed [D_WIDTH-1:0] kp_c, ki_c, kd1_c, kd2_c, iacc_c, perr_c, pd_c;
  assign kp_c   = kp_q[ch_q];
  assign ki_c   = ki_q[ch_q];
  assign kd1_c  = kd1_q[ch_q];
  assign kd2_c  = kd2_q[ch_q];
  assign iacc_c = i_acc_q[ch_q];
  assign perr_c = perr_q[ch_q];
  assign pd_c   = pd_q[ch_q];

  // Shared multiplier: gain operand is D_WIDTH, data operand D_WIDTH+1 so
  // that err +/- prev_err never wraps.
  logic signed [D_WIDTH-1:0] mul_a;
  logic signed [D_WIDTH:0]   mul_b;
  logic signed [PW-1:0]      prod, prod_sh;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MUL_P: begin
        mul_a = kp_c;
        mul_b = (D_WIDTH+1)'(err_q);
      end
      MUL_I: begin
        mul_a = ki_c;
        mul_b = (D_WIDTH+1)'(err_q) + (D_WIDTH+1)'(perr_c);
      end
      MUL_D1: begin
        mul_a = kd1_c;
        mul_b = (D_WIDTH+1)'(err_q) - (D_WIDTH+1)'(perr_c);
      end
      MUL_D2: begin
        mul_a = kd2_c;
        mul_b = (D_WIDTH+1)'(pd_c);
      end
      default: ;
    endcase
  end

  assign prod    = mul_a * mul_b;
  assign prod_sh = prod >>> Q_BITS;

  // Output stage
  logic signed [SUMW-1:0]    p_w, d_w, iacc_w, it_w, i_sum, i_max, i_min, i_cl, u_sum, o_sum, o_lim;
  logic signed [D_WIDTH-1:0] i_new;

  always_comb begin
    p_w    = SUMW'(p_q);
    d_w    = SUMW'(d_q);
    iacc_w = SUMW'(iacc_c);
    it_w   = SUMW'(it_q);
    i_sum  = iacc_w + it_w;
    i_max  = LIM_HI - p_w;
    i_min  = LIM_LO - p_w;
    i_cl   = i_sum;
    u_sum  = p_w + i_sum + d_w;
    i_new  = iacc_c;
    if (AW_MODE == 0) begin
      // Integrator window shrinks by whatever headroom p already uses.
      if (i_max[SUMW-1]) i_max = '0;
      if (!i_min[SUMW-1]) i_min = '0;
      if (i_sum > i_max)      i_cl = i_max;
      else if (i_sum < i_min) i_cl = i_min;
      // The window can exceed the storage range when p is extreme.
      i_new = sat_d(SW'(i_cl));
    end else begin
      if (u_sum >= LIM_LO && u_sum <= LIM_HI) i_new = sat_d(SW'(i_sum));
    end
    o_sum = p_w + SUMW'(i_new) + d_w;
    o_lim = o_sum;
    if (o_sum > LIM_HI)      o_lim = LIM_HI;
    else if (o_sum < LIM_LO) o_lim = LIM_LO;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      err_q       <= '0;
      p_q         <= '0;
      it_q        <= '0;
      d1_q        <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      for (int c = 0; c < N_CH; c++) begin
        kp_q[c]    <= '0;
        ki_q[c]    <= '0;
        kd1_q[c]   <= '0;
        kd2_q[c]   <= '0;
        i_acc_q[c] <= '0;
        perr_q[c]  <= '0;
        pd_q[c]    <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            case (wr_idx)
              3'd0: kp_q[wr_ch]  <= reg_data;
              3'd1: ki_q[wr_ch]  <= reg_data;
              3'd2: kd1_q[wr_ch] <= reg_data;
              3'd3: kd2_q[wr_ch] <= reg_data;
              3'd4: begin
                i_acc_q[wr_ch] <= '0;
                perr_q[wr_ch]  <= '0;
                pd_q[wr_ch]    <= '0;
              end
              default: ;
            endcase
          end
          if (accept) begin
            ch_q    <= in_ch;
            err_q   <= err_d;
            state_q <= MUL_P;
          end
        end
        MUL_P: begin
          p_q     <= sat_d(SW'(prod_sh));
          state_q <= MUL_I;
        end
        MUL_I: begin
          it_q    <= sat_d(SW'(prod_sh));
          state_q <= MUL_D1;
        end
        MUL_D1: begin
          d1_q    <= prod_sh;
          state_q <= MUL_D2;
        end
        MUL_D2: begin
          d_q     <= sat_d(SW'(d1_q) + SW'(prod_sh));
          state_q <= FIN;
        end
        FIN: begin
          if (ch_ok) begin
            i_acc_q[ch_q] <= i_new;
            perr_q[ch_q]  <= err_q;
            pd_q[ch_q]    <= d_q;
          end
          out_valid_q <= 1'b1;
          out_ch_q    <= ch_q;
          out_data_q  <= o_lim[D_WIDTH-1:0];
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/pid_mc.md
PID_MC -- requirements
Module: pid_mc

Interface
REQ-001 SHALL have parameter D_WIDTH, default 18, data/gain width (signed two's complement).
REQ-002 SHALL have parameter Q_BITS, default 15, gain fractional bits.
REQ-003 SHALL have parameter N_CH, default 4, number of independent controller channels (≥1).
REQ-004 SHALL have parameter CH_W, default 2, channel index width, where 2^CH_W ≥ N_CH.
REQ-005 SHALL have parameter LIM_MAX, default 4096, upper output limit.
REQ-006 SHALL have parameter LIM_MIN, default -4096, lower output limit.
REQ-007 SHALL have parameter AW_MODE, default 0, anti-windup mode (0 = dynamic integrator clamp, 1 = conditional integration).
REQ-008 SHALL have port clock  input  1  system clock, all logic on the rising edge.
REQ-009 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-010 SHALL have port reg_we  input  1  config write strobe, active-high.
REQ-011 SHALL have port reg_ready  output  1  config write accepted this cycle.
REQ-012 SHALL have port reg_addr  input  CH_W+3  {channel, index}, with the index in the 3 LSBs.
REQ-013 SHALL have port reg_data  input  D_WIDTH  signed config data.
REQ-014 SHALL have port in_valid  input  1  sample valid.
REQ-015 SHALL have port in_ready  output  1  sample accepted when high together with in_valid.
REQ-016 SHALL have port in_ch  input  CH_W  sample channel.
REQ-017 SHALL have port target  input  D_WIDTH  signed setpoint.
REQ-018 SHALL have port measurement  input  D_WIDTH  signed measurement.
REQ-019 SHALL have port out_valid  output  1  one-cycle result strobe.
REQ-020 SHALL have port out_ch  output  CH_W  result channel.
REQ-021 SHALL have port out_data  output  D_WIDTH  signed, limited controller output.

Function
REQ-022 SHALL keep the following per-channel storage: kp, ki, kd1, kd2, i_acc, prev_err and prev_d, each D_WIDTH wide.
REQ-023 SHALL decode config index as: 0 kp, 1 ki, 2 kd1, 3 kd2, 4 clear channel state (i_acc, prev_err, prev_d set to 0, gains kept), 5-7 ignored; writes to channels ≥N_CH are ignored.
REQ-024 SHALL drive reg_ready = (state==IDLE); a write takes effect at the edge where reg_we && reg_ready.
REQ-025 SHALL drive in_ready = (state==IDLE) && !reg_we, giving config writes priority over sample acceptance.
REQ-026 SHALL use the FSM sequence IDLE→MUL_P→MUL_I→MUL_D1→MUL_D2→FIN→IDLE, one cycle per state, leaving IDLE only on acceptance; all four products SHALL use a single shared D_WIDTH×(D_WIDTH+1) signed multiplier.
REQ-027 SHALL, on acceptance, latch in_ch and compute err = sat_D(target − measurement), where sat_D saturates to the D_WIDTH signed range.
REQ-028 SHALL compute, with ">>>" denoting an arithmetic right shift: p = sat_D((kp·err)>>>Q_BITS); it = sat_D((ki·(err+prev_err))>>>Q_BITS); d = sat_D((kd1·(err−prev_err))>>>Q_BITS + (kd2·prev_d)>>>Q_BITS).
REQ-029 SHALL, when AW_MODE=0: set i_max = max(LIM_MAX−p, 0) and i_min = min(LIM_MIN−p, 0); set i_new = clamp(i_acc+it, i_min, i_max); set out = clamp(p+i_new+d, LIM_MIN, LIM_MAX); and evaluate all sums in D_WIDTH+2 bits.
REQ-030 SHALL, when AW_MODE=1: set u = p+i_acc+it+d; if LIM_MIN ≤ u ≤ LIM_MAX then i_new = sat_D(i_acc+it), else i_new = i_acc (integration frozen); set out = clamp(p+i_new+d, LIM_MIN, LIM_MAX).
REQ-031 SHALL, in FIN, write i_acc←i_new, prev_err←err and prev_d←d for the latched channel, and register out_data, out_ch and out_valid=1.
REQ-032 SHALL hold out_valid high for exactly one cycle, the first IDLE cycle, 5 clocks after the acceptance edge; out_data and out_ch SHALL hold their value until the next result.
REQ-033 SHALL allow a new sample to be accepted in the same cycle that out_valid is high; the sustained sample rate SHALL be 1 per 6 clocks.
REQ-034 SHALL keep each channel's state isolated: processing channel c SHALL never modify the storage of any other channel.

Reset
REQ-035 SHALL, on reset low, immediately force: state=IDLE; all gains and channel state = 0; out_data = 0; out_ch = 0; out_valid = 0.
REQ-036 SHALL abort any in-flight computation on reset mid-operation, with no out_valid and no channel write-back.

Verification
Parameters for all scenarios: D_WIDTH=18, Q_BITS=15, N_CH=4, limits ±4096.
REQ-037 SHALL cover: ch0 kp=32768, other gains 0; target=300, measurement=200 -> out_valid exactly 5 clocks after acceptance, out_data=100, out_ch=0.
REQ-038 SHALL cover: ch1 ki=16384, AW_MODE=0; err=1000 repeated -> outputs 500, 1500, 2500, 3500, 4096, 4096; i_acc stays ≤4096.
REQ-039 SHALL cover: ch2 kp=32768, target=100000, measurement=0 -> err saturates to 131071 and out_data=4096; then target=−100000 -> out_data=−4096.
REQ-040 SHALL cover: interleaved samples on ch0 and ch3 with distinct gains -> each channel's results match a per-channel golden model, with no cross-talk.
REQ-041 SHALL cover: reg_we and in_valid asserted together in IDLE -> write applied, in_ready=0, sample accepted the next cycle; a config write during MUL_I -> reg_ready=0 and the write is not applied.
REQ-042 SHALL cover: reset pulse asserted during MUL_D1 -> no out_valid, all outputs 0; a subsequent sample behaves as if the block were fresh from reset.
